// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: sequencer for the 8-channel 12-bit ADC hard macro.
// Generates the ADC clock and handles power-up/power-down. It scans the
// enabled channels with a soc/eoc handshake and keeps the latest result
// per channel behind a channel-indexed read port.
module adc_scan_ctrl #(
  parameter int CLK_DIV      = 4,
  parameter int PWRUP_CYCLES = 64,
  parameter int TIMEOUT      = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        continuous,
  input  logic        start,
  input  logic [7:0]  ch_mask,
  output logic        adc_clk,
  output logic        adc_pd,
  output logic [2:0]  adc_s,
  output logic        adc_soc,
  input  logic [11:0] adc_dout,
  input  logic        adc_eoc,
  input  logic [2:0]  rd_ch,
  output logic [11:0] rd_data,
  output logic        rd_valid,
  output logic        smp_valid,
  output logic [2:0]  smp_ch,
  output logic [11:0] smp_data,
  output logic        busy,
  output logic        timeout_err
);

  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_MAX = (PWRUP_CYCLES > TIMEOUT) ? PWRUP_CYCLES : TIMEOUT;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PWRUP,
    ST_SETUP,
    ST_SOC,
    ST_WAIT_EOC,
    ST_CAPTURE
  } state_t;

  state_t           state_reg;
  logic [DIV_W-1:0] div_cnt_reg;
  logic             adc_clk_reg;
  logic             fall_tick;
  logic             eoc_meta_reg;
  logic             eoc_sync_reg;
  logic             eoc_prev_reg;
  logic             eoc_rise;
  logic [2:0]       ptr_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             fall_seen_reg;
  logic             adc_pd_reg;
  logic             adc_soc_reg;
  logic [2:0]       adc_s_reg;
  logic             smp_valid_reg;
  logic [2:0]       smp_ch_reg;
  logic [11:0]      smp_data_reg;
  logic             timeout_err_reg;

  logic [2:0]       low_bit;
  logic [2:0]       next_ptr;
  logic             next_found;
  logic             next_wrap;
  logic             scan_done;
  logic             timeout_evt;
  logic             cap_we;

  logic [7:0][11:0] res_all;
  logic [7:0]       valid_all;

  // Free-running divider; adc_clk toggles whenever the counter wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg <= '0;
      adc_clk_reg <= 1'b0;
    end else if (div_cnt_reg == DIV_LAST) begin
      div_cnt_reg <= '0;
      adc_clk_reg <= ~adc_clk_reg;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  // adc_clk goes 1->0 at the end of this cycle
  assign fall_tick = (div_cnt_reg == DIV_LAST) && adc_clk_reg;

  // Two-flop synchronizer on eoc plus a history flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eoc_meta_reg <= 1'b0;
      eoc_sync_reg <= 1'b0;
      eoc_prev_reg <= 1'b0;
    end else begin
      eoc_meta_reg <= adc_eoc;
      eoc_sync_reg <= eoc_meta_reg;
      eoc_prev_reg <= eoc_sync_reg;
    end
  end

  assign eoc_rise = eoc_sync_reg & ~eoc_prev_reg;

  // Lowest enabled channel, used as the first channel of a pass
  always_comb begin
    low_bit = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (ch_mask[i]) low_bit = 3'(i);
    end
  end

  // Next enabled channel after the pointer; wrapping past 7 (including
  // landing back on the pointer itself) marks the end of a pass
  always_comb begin
    next_ptr   = ptr_reg;
    next_found = 1'b0;
    next_wrap  = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (!next_found && ch_mask[3'(int'(ptr_reg) + k)]) begin
        next_found = 1'b1;
        next_ptr   = 3'(int'(ptr_reg) + k);
        next_wrap  = (int'(ptr_reg) + k) > 7;
      end
    end
  end

  assign scan_done   = !next_found || (next_wrap && !continuous);
  assign timeout_evt = enable && (state_reg == ST_WAIT_EOC) && !eoc_rise && (cnt_reg == TO_LAST);
  assign cap_we      = enable && (state_reg == ST_CAPTURE) && (ch_mask != 8'd0);

  // Scan sequencer with registered ADC controls, sample strobe and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      ptr_reg         <= 3'd0;
      cnt_reg         <= '0;
      fall_seen_reg   <= 1'b0;
      adc_pd_reg      <= 1'b1;
      adc_soc_reg     <= 1'b0;
      adc_s_reg       <= 3'd0;
      smp_valid_reg   <= 1'b0;
      smp_ch_reg      <= 3'd0;
      smp_data_reg    <= 12'd0;
      timeout_err_reg <= 1'b0;
    end else begin
      smp_valid_reg <= 1'b0;

      // A timeout in the same cycle as start keeps the flag set
      if (timeout_evt) begin
        timeout_err_reg <= 1'b1;
      end else if (start) begin
        timeout_err_reg <= 1'b0;
      end

      if (!enable) begin
        state_reg   <= ST_IDLE;
        adc_soc_reg <= 1'b0;
        adc_pd_reg  <= 1'b1;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if ((ch_mask != 8'd0) && (start || continuous)) begin
              ptr_reg <= low_bit;
              cnt_reg <= '0;
              if (adc_pd_reg) begin
                state_reg  <= ST_PWRUP;
                adc_pd_reg <= 1'b0;
              end else begin
                state_reg     <= ST_SETUP;
                adc_s_reg     <= low_bit;
                fall_seen_reg <= 1'b0;
              end
            end
          end

          ST_PWRUP: begin
            if (cnt_reg == PWRUP_LAST) begin
              state_reg     <= ST_SETUP;
              adc_s_reg     <= ptr_reg;
              fall_seen_reg <= 1'b0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end

          ST_SETUP: begin
            // Second fall after entry guarantees a full adc_clk period of adc_s setup
            if (fall_tick) begin
              if (fall_seen_reg) begin
                state_reg   <= ST_SOC;
                adc_soc_reg <= 1'b1;
              end else begin
                fall_seen_reg <= 1'b1;
              end
            end
          end

          ST_SOC: begin
            if (fall_tick) begin
              state_reg   <= ST_WAIT_EOC;
              adc_soc_reg <= 1'b0;
              cnt_reg     <= '0;
            end
          end

          ST_WAIT_EOC: begin
            if (eoc_rise) begin
              state_reg <= ST_CAPTURE;
            end else if (cnt_reg == TO_LAST) begin
              // Abandon the conversion and move on without a result
              if (scan_done) begin
                state_reg  <= ST_IDLE;
                adc_pd_reg <= 1'b1;
              end else begin
                state_reg     <= ST_SETUP;
                ptr_reg       <= next_ptr;
                adc_s_reg     <= next_ptr;
                fall_seen_reg <= 1'b0;
              end
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end

          ST_CAPTURE: begin
            if (ch_mask != 8'd0) begin
              smp_valid_reg <= 1'b1;
              smp_ch_reg    <= ptr_reg;
              smp_data_reg  <= adc_dout;
            end
            if (scan_done) begin
              state_reg  <= ST_IDLE;
              adc_pd_reg <= 1'b1;
            end else begin
              state_reg     <= ST_SETUP;
              ptr_reg       <= next_ptr;
              adc_s_reg     <= next_ptr;
              fall_seen_reg <= 1'b0;
            end
          end

          default: begin
            state_reg   <= ST_IDLE;
            adc_soc_reg <= 1'b0;
            adc_pd_reg  <= 1'b1;
          end
        endcase
      end
    end
  end

  // Per-channel result and valid registers, written at the end of CAPTURE
  for (genvar gi = 0; gi < 8; gi++) begin : g_res
    logic [11:0] res_reg;
    logic        val_reg;

    // Capture adc_dout for this channel when it is the one being converted
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        res_reg <= 12'd0;
        val_reg <= 1'b0;
      end else if (cap_we && (ptr_reg == 3'(gi))) begin
        res_reg <= adc_dout;
        val_reg <= 1'b1;
      end
    end

    assign res_all[gi]   = res_reg;
    assign valid_all[gi] = val_reg;
  end

  assign rd_data     = res_all[rd_ch];
  assign rd_valid    = valid_all[rd_ch];

  assign adc_clk     = adc_clk_reg;
  assign adc_pd      = adc_pd_reg;
  assign adc_s       = adc_s_reg;
  assign adc_soc     = adc_soc_reg;
  assign smp_valid   = smp_valid_reg;
  assign smp_ch      = smp_ch_reg;
  assign smp_data    = smp_data_reg;
  assign busy        = (state_reg != ST_IDLE);
  assign timeout_err = timeout_err_reg;

endmodule

// File: doc/adc_scan_ctrl.md
Name: adc_scan_ctrl

Overview:
- Sequencer that drives the on-chip 8-channel 12-bit ADC hard macro. That macro has these ports: clk, pd, s[2:0], soc, dout[11:0] and eoc.
- The block generates the ADC clock, handles power-down and power-up, and scans the enabled channels.
- It runs each conversion with a soc/eoc handshake and keeps the latest result for each channel.
- It sits between the ADC wrapper and the SoC peripheral bus glue. The glue reads results through a simple channel-indexed port and can also take a per-sample strobe.

Parameters:
- CLK_DIV, 4: adc_clk half-period in clk cycles; adc_clk = clk/(2*CLK_DIV); minimum 1.
- PWRUP_CYCLES, 64: clk cycles to wait after adc_pd falls before the first conversion.
- TIMEOUT, 4096: maximum clk cycles in WAIT_EOC before the conversion is abandoned.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  master enable; 0 powers the ADC down.
- continuous  in  1  1 = repeat scans forever; 0 = one pass per start.
- start  in  1  one-cycle pulse that begins a pass; also clears timeout_err.
- ch_mask  in  8  enabled channels; bit n = channel n.
- adc_clk  out  1  to ADC clk.
- adc_pd  out  1  to ADC pd; 1 = powered down.
- adc_s  out  3  to ADC s; channel select.
- adc_soc  out  1  to ADC soc.
- adc_dout  in  12  from ADC dout.
- adc_eoc  in  1  from ADC eoc.
- rd_ch  in  3  read channel index.
- rd_data  out  12  stored result for rd_ch.
- rd_valid  out  1  result for rd_ch has been captured at least once.
- smp_valid  out  1  one-cycle strobe for a new sample.
- smp_ch  out  3  channel of the strobed sample.
- smp_data  out  12  value of the strobed sample.
- busy  out  1  FSM is not in IDLE.
- timeout_err  out  1  sticky; set when an eoc timeout occurs.

Behaviour:

Reset:
- adc_pd=1; adc_clk, adc_soc, adc_s, smp_* and busy are 0; timeout_err=0.
- All 8 result registers and valid bits are 0. FSM is in IDLE. Divider count is 0.

Clock divider:
- Free-running counter 0..CLK_DIV-1; adc_clk toggles when the counter wraps.
- fall_tick = the cycle in which adc_clk goes 1->0.

eoc input:
- adc_eoc passes through a 2-flop synchronizer followed by rising-edge detect; the result is eoc_rise.

FSM states: IDLE, PWRUP, SETUP, SOC, WAIT_EOC, CAPTURE.

- IDLE
  - Goes to PWRUP when enable=1, ch_mask!=0, and either start=1 or continuous=1.
  - On entry the channel pointer is set to the lowest set bit of ch_mask.
- PWRUP
  - adc_pd=0; count PWRUP_CYCLES clk cycles, then go to SETUP.
  - PWRUP is skipped (straight to SETUP) if adc_pd was already 0.
- SETUP
  - Drive adc_s with the pointer.
  - Go to SOC at the second fall_tick after entry, so adc_s is stable for at least one adc_clk period before soc.
- SOC
  - adc_soc=1 from entry until the next fall_tick (one full adc_clk period, covering exactly one adc_clk rise). Then go to WAIT_EOC.
- WAIT_EOC
  - adc_s is held.
  - On eoc_rise, go to CAPTURE.
  - On reaching TIMEOUT cycles: set timeout_err, discard the conversion, and advance as for CAPTURE without writing a result.
- CAPTURE
  - Write adc_dout into result[ptr] and set valid[ptr].
  - Next cycle: smp_valid=1 for exactly one cycle, with smp_ch=ptr and smp_data=the value written.
  - Advance the pointer to the next set bit of the ch_mask value sampled in this cycle, ascending, with wrap 7->0.
  - If the pass has wrapped past channel 7, or the mask has only its current bit, the pass is complete.
  - Pass complete and continuous=0: go to IDLE and set adc_pd=1.
  - Otherwise: go to SETUP.

Abort:
- enable=0 in any state: next cycle the FSM is in IDLE with adc_soc=0 and adc_pd=1.
- A pending conversion is discarded; no result is written and no strobe is issued.
- ch_mask becoming 0 at a CAPTURE ends the scan the same way.

Read port:
- rd_data and rd_valid are combinational from rd_ch.
- A read of the same channel in its CAPTURE cycle returns the old value; the new value appears the following cycle.

Other rules:
- start while busy is ignored, except that it still clears timeout_err.
- If start and a timeout occur in the same cycle, the set wins.
- busy = 1 in every state except IDLE.
- adc_s changes only in SETUP entry.

Test Plan:
(Bench uses CLK_DIV=2, PWRUP_CYCLES=8, TIMEOUT=64. The ADC model raises eoc 20 clk cycles after the soc rise and returns dout=0x100+channel.)

1. Single pass
   - Stimulus: reset, then enable=1, continuous=0, ch_mask=0x05, start pulse.
   - Required: adc_pd falls; the first soc comes at least 8 clk later with adc_s=0; two smp_valid strobes, (ch0, 0x100) then (ch2, 0x102).
   - Then: IDLE, adc_pd=1, busy=0; rd_ch=2 gives 0x102 with rd_valid=1; rd_ch=1 gives rd_valid=0.
2. soc timing
   - Required: every soc high lasts exactly 4 clk cycles and begins 4 clk cycles after an adc_clk fall.
   - Required: adc_s is stable from at least 4 clk cycles before the soc rise until eoc.
3. Continuous scan
   - Stimulus: continuous=1, ch_mask=0x81.
   - Required: strobes alternate ch0, ch7, ch0, ...; PWRUP occurs only once.
   - Then change mask to 0x02 mid-scan: the next channel after the current one is ch1.
4. Timeout
   - Stimulus: model never raises eoc.
   - Required: 64 cycles after entering WAIT_EOC, timeout_err=1; no strobe; the scan proceeds to the next channel.
   - Then a start pulse clears timeout_err.
5. Abort
   - Stimulus: enable=0 during SOC.
   - Required: next cycle adc_soc=0, adc_pd=1, busy=0; no strobe; the results are unchanged.
6. Async reset
   - Stimulus: rst_n=0 mid-WAIT_EOC.
   - Required: all outputs are at their reset values immediately, without waiting for a clk edge; rd_valid=0 for all channels.
